// File: rtl/mips_decode_issue_pkg.sv
// Shared definitions for the decode/issue stage: category codes,
// register-field positions and the funct bit separating mult from div.
package mips_decode_issue_pkg;

    localparam int CAT_W = 4;

    localparam logic [CAT_W-1:0] CAT_OTHER   = 4'd0;
    localparam logic [CAT_W-1:0] CAT_RSHIFT  = 4'd1;
    localparam logic [CAT_W-1:0] CAT_RSHIFTV = 4'd2;
    localparam logic [CAT_W-1:0] CAT_RHILO   = 4'd3;
    localparam logic [CAT_W-1:0] CAT_RLONG   = 4'd4;
    localparam logic [CAT_W-1:0] CAT_RARITH  = 4'd5;
    localparam logic [CAT_W-1:0] CAT_RLOGIC  = 4'd6;
    localparam logic [CAT_W-1:0] CAT_RCOMP   = 4'd7;
    localparam logic [CAT_W-1:0] CAT_BRANCH  = 4'd8;
    localparam logic [CAT_W-1:0] CAT_JUMP    = 4'd9;
    localparam logic [CAT_W-1:0] CAT_ARITH   = 4'd10;
    localparam logic [CAT_W-1:0] CAT_COMP    = 4'd11;
    localparam logic [CAT_W-1:0] CAT_LOGIC   = 4'd12;
    localparam logic [CAT_W-1:0] CAT_STORE   = 4'd13;
    localparam logic [CAT_W-1:0] CAT_LOAD    = 4'd14;

    // Register-specifier fields of the instruction word
    localparam int REG_W  = 5;
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;

    // Upper opcode bits shared by beq/bne (the only branches that read rt)
    localparam int              OPHI_LSB   = 27;
    localparam int              OPHI_W     = 5;
    localparam logic [OPHI_W-1:0] BEQ_BNE_OPHI = 5'b00010;

    // funct[1] is set for div/divu and clear for mult/multu
    localparam int FUNCT_DIV_BIT = 1;

    localparam int HILO_CNT_W = 6;

endpackage

// File: rtl/mips_decode_issue_hazard.sv
// Load-use hazard detection: compares the source registers of the
// instruction on the input side against a load sitting in ID/EX and a
// load that has just moved on into execute (the shadow).
module mips_decode_issue_hazard
    import mips_decode_issue_pkg::*;
(
    input  logic              in_valid,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [OPHI_W-1:0] in_ophi,
    input  logic [CAT_W-1:0]  in_category,
    input  logic              out_valid,
    input  logic [CAT_W-1:0]  out_category,
    input  logic [REG_W-1:0]  out_rt,
    input  logic              shadow_valid,
    input  logic [REG_W-1:0]  shadow_rt,
    output logic              stall_load
);

    logic uses_rs;
    logic uses_rt;

    // A written register r conflicts if the incoming instruction reads it; $zero never does
    function automatic logic reg_match(input logic [REG_W-1:0] r,
                                       input logic [REG_W-1:0] rs,
                                       input logic [REG_W-1:0] rt,
                                       input logic use_rs,
                                       input logic use_rt);
        return (r != '0) && ((use_rs && rs == r) || (use_rt && rt == r));
    endfunction

    // Source-operand usage by category, then the stall decision
    always_comb begin
        uses_rs = !(in_category == CAT_OTHER || in_category == CAT_JUMP ||
                    in_category == CAT_RSHIFT);
        uses_rt = (in_category >= CAT_RSHIFT && in_category <= CAT_RCOMP) ||
                  (in_category == CAT_STORE) ||
                  (in_category == CAT_BRANCH && in_ophi == BEQ_BNE_OPHI);
        stall_load = in_valid &&
            ((out_valid && out_category == CAT_LOAD &&
              reg_match(out_rt, in_rs, in_rt, uses_rs, uses_rt)) ||
             (shadow_valid &&
              reg_match(shadow_rt, in_rs, in_rt, uses_rs, uses_rt)));
    end

endmodule

// File: rtl/mips_decode_issue.sv
// Decode-to-execute issue stage: single-entry ID/EX register with a
// valid/ready handshake, load-use and HI/LO bubbles, and branch flush.
module mips_decode_issue
    import mips_decode_issue_pkg::*;
#(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [3:0]  in_category,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [3:0]  out_category,
    output logic        hilo_busy,
    output logic        stall_load
);

    localparam logic [HILO_CNT_W-1:0] MULT_CNT = HILO_CNT_W'(MULT_LAT);
    localparam logic [HILO_CNT_W-1:0] DIV_CNT  = HILO_CNT_W'(DIV_LAT);

    logic                  out_valid_q, out_valid_d;
    logic [31:0]           out_instr_q, out_instr_d;
    logic [31:0]           out_pc_q, out_pc_d;
    logic [CAT_W-1:0]      out_category_q, out_category_d;
    logic                  shadow_valid_q, shadow_valid_d;
    logic [REG_W-1:0]      shadow_rt_q, shadow_rt_d;
    logic [HILO_CNT_W-1:0] hilo_cnt_q, hilo_cnt_d;

    logic stall_hilo;
    logic accept;
    logic out_fire;

    mips_decode_issue_hazard u_hazard (
        .in_valid     (in_valid),
        .in_rs        (in_instr[RS_LSB +: REG_W]),
        .in_rt        (in_instr[RT_LSB +: REG_W]),
        .in_ophi      (in_instr[OPHI_LSB +: OPHI_W]),
        .in_category  (in_category),
        .out_valid    (out_valid_q),
        .out_category (out_category_q),
        .out_rt       (out_instr_q[RT_LSB +: REG_W]),
        .shadow_valid (shadow_valid_q),
        .shadow_rt    (shadow_rt_q),
        .stall_load   (stall_load)
    );

    // Handshake qualification: HI/LO readers wait out any multiply/divide in flight
    always_comb begin
        stall_hilo = in_valid && (in_category == CAT_RHILO || in_category == CAT_RLONG) &&
                     (hilo_cnt_q != '0);
        in_ready   = !flush && !stall_load && !stall_hilo && (!out_valid_q || out_ready);
        accept     = in_valid && in_ready;
        out_fire   = out_valid_q && out_ready;
    end

    // Next state for ID/EX, the load shadow and the HI/LO busy counter
    always_comb begin
        out_valid_d    = out_valid_q;
        out_instr_d    = out_instr_q;
        out_pc_d       = out_pc_q;
        out_category_d = out_category_q;
        shadow_valid_d = 1'b0;
        shadow_rt_d    = shadow_rt_q;
        hilo_cnt_d     = hilo_cnt_q;

        if (out_fire && out_category_q == CAT_LOAD) begin
            shadow_valid_d = 1'b1;
            shadow_rt_d    = out_instr_q[RT_LSB +: REG_W];
        end

        if (flush) begin
            out_valid_d    = 1'b0;
            shadow_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d    = 1'b1;
            out_instr_d    = in_instr;
            out_pc_d       = in_pc;
            out_category_d = in_category;
        end else if (out_fire) begin
            out_valid_d    = 1'b0;
        end

        // Flush leaves the counter running so the busy window stays conservative
        if (accept && in_category == CAT_RLONG) begin
            hilo_cnt_d = in_instr[FUNCT_DIV_BIT] ? DIV_CNT : MULT_CNT;
        end else if (hilo_cnt_q != '0) begin
            hilo_cnt_d = hilo_cnt_q - 1'b1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid_q    <= 1'b0;
            out_instr_q    <= '0;
            out_pc_q       <= '0;
            out_category_q <= CAT_OTHER;
            shadow_valid_q <= 1'b0;
            shadow_rt_q    <= '0;
            hilo_cnt_q     <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_instr_q    <= out_instr_d;
            out_pc_q       <= out_pc_d;
            out_category_q <= out_category_d;
            shadow_valid_q <= shadow_valid_d;
            shadow_rt_q    <= shadow_rt_d;
            hilo_cnt_q     <= hilo_cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_instr    = out_instr_q;
    assign out_pc       = out_pc_q;
    assign out_category = out_category_q;
    assign hilo_busy    = (hilo_cnt_q != '0);

endmodule

// File: tb/tb_mips_decode_issue.sv
// Directed bench for the decode/issue stage. Inputs change 1ns after the
// rising edge; outputs are checked 3ns later, well clear of either edge.
module tb_mips_decode_issue;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [3:0]  in_category;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [3:0]  out_category;
    logic        hilo_busy;
    logic        stall_load;

    int vectors;
    int miscompares;

    localparam logic [3:0] C_RHILO = 4'd3, C_RLONG = 4'd4, C_RARITH = 4'd5, C_LOAD = 4'd14;

    localparam logic [31:0] LW_T0   = {6'b100011, 5'd16, 5'd8, 16'h0004};
    localparam logic [31:0] ADD_DEP = {6'd0, 5'd8, 5'd10, 5'd9, 5'd0, 6'h20};
    localparam logic [31:0] ADD_IND = {6'd0, 5'd9, 5'd10, 5'd11, 5'd0, 6'h20};
    localparam logic [31:0] LW_ZERO = {6'b100011, 5'd16, 5'd0, 16'h0008};
    localparam logic [31:0] ADD_Z   = {6'd0, 5'd0, 5'd0, 5'd12, 5'd0, 6'h20};
    localparam logic [31:0] MULT    = {6'd0, 5'd8, 5'd9, 10'd0, 6'h18};
    localparam logic [31:0] MFHI    = {6'd0, 10'd0, 5'd10, 5'd0, 6'h10};
    localparam logic [31:0] DIV     = {6'd0, 5'd8, 5'd9, 10'd0, 6'h1a};
    localparam logic [31:0] ADD_A   = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    localparam logic [31:0] ADD_B   = {6'd0, 5'd4, 5'd5, 5'd6, 5'd0, 6'h20};

    mips_decode_issue #(.MULT_LAT(4), .DIV_LAT(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .in_category  (in_category),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_category (out_category),
        .hilo_busy    (hilo_busy),
        .stall_load   (stall_load)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic present(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                           input logic [3:0] cat);
        in_valid    = v;
        in_instr    = ins;
        in_pc       = pc;
        in_category = cat;
    endtask

    task automatic idle(input int n);
        present(1'b0, 32'h0, 32'h0, 4'd0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        present(1'b0, 32'h0, 32'h0, 4'd0);
        tick(); tick();
        settle();
        if ({out_valid, out_instr, out_pc, out_category} !== {1'b0, 32'h0, 32'h0, 4'd0}) begin
            $display("FAIL reset_out: got v=%b i=%h pc=%h c=%0d want 0/0/0/0",
                     out_valid, out_instr, out_pc, out_category);
            miscompares++;
        end
        vectors++;
        if ({hilo_busy, stall_load, in_ready} !== 3'b001) begin
            $display("FAIL reset_ctrl: got busy/stall/rdy=%b%b%b want 001", hilo_busy, stall_load, in_ready);
            miscompares++;
        end
        vectors++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        out_ready = 1'b1;
        present(1'b1, LW_T0, 32'h100, C_LOAD);
        settle();
        if ({in_ready, stall_load} !== 2'b10) begin
            $display("FAIL lu_lw_accept: got rdy/stall=%b%b want 10", in_ready, stall_load);
            miscompares++;
        end
        vectors++;
        tick();
        present(1'b1, ADD_DEP, 32'h104, C_RARITH);
        settle();
        if ({out_valid, out_instr, stall_load, in_ready} !== {1'b1, LW_T0, 2'b10}) begin
            $display("FAIL lu_stall_idex: got v=%b i=%h stall=%b rdy=%b want 1/%h/1/0",
                     out_valid, out_instr, stall_load, in_ready, LW_T0);
            miscompares++;
        end
        vectors++;
        tick();
        settle();
        if ({out_valid, stall_load, in_ready} !== 3'b010) begin
            $display("FAIL lu_stall_shadow: got v/stall/rdy=%b%b%b want 010", out_valid, stall_load, in_ready);
            miscompares++;
        end
        vectors++;
        tick();
        settle();
        if ({out_valid, stall_load, in_ready} !== 3'b001) begin
            $display("FAIL lu_release: got v/stall/rdy=%b%b%b want 001", out_valid, stall_load, in_ready);
            miscompares++;
        end
        vectors++;
        tick();
        present(1'b0, 32'h0, 32'h0, 4'd0);
        settle();
        if ({out_valid, out_instr, out_pc, out_category} !== {1'b1, ADD_DEP, 32'h104, C_RARITH}) begin
            $display("FAIL lu_add_out: got v=%b i=%h pc=%h c=%0d want 1/%h/104/5",
                     out_valid, out_instr, out_pc, out_category, ADD_DEP);
            miscompares++;
        end
        vectors++;
        idle(2);
    endtask

    task automatic test_independent();
        out_ready = 1'b1;
        present(1'b1, LW_T0, 32'h200, C_LOAD);
        tick();
        present(1'b1, ADD_IND, 32'h204, C_RARITH);
        settle();
        if ({out_valid, out_instr, stall_load, in_ready} !== {1'b1, LW_T0, 2'b01}) begin
            $display("FAIL ind_no_stall: got v=%b i=%h stall=%b rdy=%b want 1/%h/0/1",
                     out_valid, out_instr, stall_load, in_ready, LW_T0);
            miscompares++;
        end
        vectors++;
        tick();
        present(1'b0, 32'h0, 32'h0, 4'd0);
        settle();
        if ({out_valid, out_instr, out_pc} !== {1'b1, ADD_IND, 32'h204}) begin
            $display("FAIL ind_back_to_back: got v=%b i=%h pc=%h want 1/%h/204",
                     out_valid, out_instr, out_pc, ADD_IND);
            miscompares++;
        end
        vectors++;
        tick();
        settle();
        if (out_valid !== 1'b0) begin
            $display("FAIL ind_drain: got v=%b want 0", out_valid);
            miscompares++;
        end
        vectors++;
        idle(2);
    endtask

    task automatic test_load_zero();
        out_ready = 1'b1;
        present(1'b1, LW_ZERO, 32'h300, C_LOAD);
        tick();
        present(1'b1, ADD_Z, 32'h304, C_RARITH);
        settle();
        if ({stall_load, in_ready} !== 2'b01) begin
            $display("FAIL zero_no_stall: got stall/rdy=%b%b want 01", stall_load, in_ready);
            miscompares++;
        end
        vectors++;
        tick();
        present(1'b0, 32'h0, 32'h0, 4'd0);
        settle();
        if ({out_valid, out_instr} !== {1'b1, ADD_Z}) begin
            $display("FAIL zero_add_out: got v=%b i=%h want 1/%h", out_valid, out_instr, ADD_Z);
            miscompares++;
        end
        vectors++;
        idle(2);
    endtask

    task automatic test_mult_mfhi();
        out_ready = 1'b1;
        present(1'b1, MULT, 32'h400, C_RLONG);
        settle();
        if ({in_ready, hilo_busy} !== 2'b10) begin
            $display("FAIL mul_accept: got rdy/busy=%b%b want 10", in_ready, hilo_busy);
            miscompares++;
        end
        vectors++;
        tick();
        present(1'b1, MFHI, 32'h404, C_RHILO);
        for (int i = 0; i < 4; i++) begin
            settle();
            if ({hilo_busy, in_ready} !== 2'b10) begin
                $display("FAIL mul_busy_cycle%0d: got busy/rdy=%b%b want 10", i, hilo_busy, in_ready);
                miscompares++;
            end
            vectors++;
            tick();
        end
        settle();
        if ({hilo_busy, in_ready} !== 2'b01) begin
            $display("FAIL mul_mfhi_release: got busy/rdy=%b%b want 01", hilo_busy, in_ready);
            miscompares++;
        end
        vectors++;
        tick();
        present(1'b0, 32'h0, 32'h0, 4'd0);
        settle();
        if ({out_valid, out_instr, out_category} !== {1'b1, MFHI, C_RHILO}) begin
            $display("FAIL mul_mfhi_out: got v=%b i=%h c=%0d want 1/%h/3",
                     out_valid, out_instr, out_category, MFHI);
            miscompares++;
        end
        vectors++;
        idle(2);
    endtask

    task automatic test_backpressure_flush();
        out_ready = 1'b0;
        present(1'b1, ADD_A, 32'h500, C_RARITH);
        tick();
        present(1'b1, ADD_B, 32'h504, C_RARITH);
        for (int i = 0; i < 2; i++) begin
            settle();
            if ({out_valid, out_instr, out_pc, in_ready} !== {1'b1, ADD_A, 32'h500, 1'b0}) begin
                $display("FAIL bp_hold%0d: got v=%b i=%h pc=%h rdy=%b want 1/%h/500/0",
                         i, out_valid, out_instr, out_pc, in_ready, ADD_A);
                miscompares++;
            end
            vectors++;
            tick();
        end
        flush = 1'b1;
        settle();
        if ({out_valid, out_instr, in_ready} !== {1'b1, ADD_A, 1'b0}) begin
            $display("FAIL bp_flush_cycle: got v=%b i=%h rdy=%b want 1/%h/0",
                     out_valid, out_instr, in_ready, ADD_A);
            miscompares++;
        end
        vectors++;
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        settle();
        if ({out_valid, in_ready} !== 2'b01) begin
            $display("FAIL bp_after_flush: got v/rdy=%b%b want 01", out_valid, in_ready);
            miscompares++;
        end
        vectors++;
        tick();
        present(1'b0, 32'h0, 32'h0, 4'd0);
        settle();
        if ({out_valid, out_instr, out_pc} !== {1'b1, ADD_B, 32'h504}) begin
            $display("FAIL bp_b_later: got v=%b i=%h pc=%h want 1/%h/504",
                     out_valid, out_instr, out_pc, ADD_B);
            miscompares++;
        end
        vectors++;
        idle(2);
    endtask

    task automatic test_reset_mid_divide();
        out_ready = 1'b1;
        present(1'b1, DIV, 32'h600, C_RLONG);
        tick();
        idle(11);
        out_ready = 1'b0;
        present(1'b1, ADD_A, 32'h640, C_RARITH);
        tick();
        present(1'b0, 32'h0, 32'h0, 4'd0);
        settle();
        if ({hilo_busy, out_valid, out_category} !== {2'b11, C_RARITH}) begin
            $display("FAIL div_busy_at20: got busy=%b v=%b c=%0d want 1/1/5", hilo_busy, out_valid, out_category);
            miscompares++;
        end
        vectors++;
        reset = 1'b0;
        tick();
        settle();
        if ({hilo_busy, out_valid, out_category} !== {2'b00, 4'd0}) begin
            $display("FAIL div_reset: got busy=%b v=%b c=%0d want 0/0/0", hilo_busy, out_valid, out_category);
            miscompares++;
        end
        vectors++;
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_load_use();
        test_independent();
        test_load_zero();
        test_mult_mfhi();
        test_backpressure_flush();
        test_reset_mid_divide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
